// File: rtl/shift_arbiter_pkg.sv
// Shared definitions for shift_arbiter: operand widths, op codes, FSM states
// and the op-legality helper used by the sequencer.
package shift_arbiter_pkg;

  localparam int SHIFT_W = 32;
  localparam int AMT_W   = 5;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b01;
  localparam logic [1:0] OP_ROL = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS1 = 2'd1,
    ST_PASS2 = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Rotate is only a legal op when the two-pass sequencer is built in.
  function automatic logic op_legal(input logic [1:0] op, input logic rot_en);
    return (op == OP_SLL) || (op == OP_SRA) || (rot_en && (op == OP_ROL));
  endfunction

endpackage

// File: rtl/barrelshift.sv
// Combinational 32-bit barrel shifter: shift=0 logical left, shift=1 arithmetic right.
module barrelshift
  import shift_arbiter_pkg::*;
(
  input  logic [SHIFT_W-1:0] data_operandA,
  input  logic [AMT_W-1:0]   ctrl_shiftamt,
  input  logic               shift,
  output logic [SHIFT_W-1:0] data_result
);

  // Kept as if/else rather than ?: so the right shift stays signed.
  always_comb begin
    if (shift) data_result = $signed(data_operandA) >>> ctrl_shiftamt;
    else       data_result = data_operandA << ctrl_shiftamt;
  end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin sharing of one barrelshift between the ALU (req 0) and decrypt engine (req 1).
// Define ROTATE_EN to sequence rotate-left as SLL followed by a masked SRA pass.
module shift_arbiter
  import shift_arbiter_pkg::*;
#(
  parameter logic RR_INIT = 1'b0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [SHIFT_W-1:0] req0_data,
  input  logic [AMT_W-1:0]   req0_amt,
  input  logic [1:0]         req0_op,
  input  logic [SHIFT_W-1:0] req1_data,
  input  logic [AMT_W-1:0]   req1_amt,
  input  logic [1:0]         req1_op,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [SHIFT_W-1:0] resp_data,
  output logic               resp_id,
  output logic               resp_err
);

`ifdef ROTATE_EN
  localparam logic ROT_EN = 1'b1;
`else
  localparam logic ROT_EN = 1'b0;
`endif

  state_e             state;
  logic               ptr;
  logic               grant;
  logic               grant_valid;
  logic               accept;
  logic [SHIFT_W-1:0] data_q;
  logic [AMT_W-1:0]   amt_q;
  logic [1:0]         op_q;
  logic [AMT_W-1:0]   sh_amt;
  logic               sh_sra;
  logic [SHIFT_W-1:0] sh_out;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    grant       = ptr;
    grant_valid = 1'b0;
    if (req_valid[ptr]) begin
      grant       = ptr;
      grant_valid = 1'b1;
    end else if (req_valid[~ptr]) begin
      grant       = ~ptr;
      grant_valid = 1'b1;
    end
  end

  // Ready is suppressed while reset is low so an aborted cycle never handshakes.
  assign accept = reset && (state == ST_IDLE) && grant_valid;

  always_comb begin
    req_ready = 2'b00;
    if (accept) req_ready[grant] = 1'b1;
  end

  // Shifter control muxed by state; the second rotate pass shifts right by 32-amt.
  always_comb begin
    sh_amt = amt_q;
    sh_sra = (op_q == OP_SRA);
`ifdef ROTATE_EN
    if (state == ST_PASS2) begin
      sh_amt = 5'd0 - amt_q;
      sh_sra = 1'b1;
    end
`endif
  end

  barrelshift u_shift (
    .data_operandA (data_q),
    .ctrl_shiftamt (sh_amt),
    .shift         (sh_sra),
    .data_result   (sh_out)
  );

`ifdef ROTATE_EN
  logic [SHIFT_W-1:0] rot_mask;
  assign rot_mask = ~({SHIFT_W{1'b1}} << amt_q);
`endif

  // NOTE: operand latches carry no reset; they are only read after a handshake loads them.
  always_ff @(posedge clock) begin
    if (accept) begin
      data_q <= grant ? req1_data : req0_data;
      amt_q  <= grant ? req1_amt  : req0_amt;
      op_q   <= grant ? req1_op   : req0_op;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= ST_IDLE;
      ptr        <= RR_INIT;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= 1'b0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            resp_id <= grant;
            ptr     <= ~grant;
            state   <= ST_PASS1;
          end
        end
        ST_PASS1: begin
          if (!op_legal(op_q, ROT_EN)) begin
            resp_data  <= data_q;
            resp_err   <= 1'b1;
            resp_valid <= 1'b1;
            state      <= ST_RESP;
          end else begin
            resp_data <= sh_out;
            resp_err  <= 1'b0;
`ifdef ROTATE_EN
            if (op_q == OP_ROL && amt_q != '0) begin
              state <= ST_PASS2;
            end else begin
              resp_valid <= 1'b1;
              state      <= ST_RESP;
            end
`else
            resp_valid <= 1'b1;
            state      <= ST_RESP;
`endif
          end
        end
`ifdef ROTATE_EN
        ST_PASS2: begin
          resp_data  <= resp_data | (sh_out & rot_mask);
          resp_valid <= 1'b1;
          state      <= ST_RESP;
        end
`endif
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
